fp_issue_sched: RTL and testbench
=================================

Name: fp_issue_sched

Overview:
- Issue and writeback scheduler for the floating-point datapath.
- Accepts one decoded FP op per cycle, carried as an fp_pkt_t with one-hot fields fp_add, fp_mul and fp_div.
- Starts the fixed-latency add pipe, the fixed-latency mul pipe, or the iterative divider.
- Guarantees the single FP writeback port never sees two results in the same cycle, using a reservation shift register plus a divide result holding state.

Parameters:
- ADD_LAT, 3, cycles from add_start to add result valid at writeback.
- MUL_LAT, 4, cycles from mul_start to mul result valid at writeback.
- RSV_DEPTH, 8, reservation register length; must exceed max(ADD_LAT, MUL_LAT); both latencies are at least 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an FP op.
- issue_pkt  in  3  fp_pkt_t {fp_add, fp_mul, fp_div}.
- issue_rd  in  5  destination register.
- issue_ready  out  1  op accepted this cycle when issue_valid and issue_ready are both high.
- flush  in  1  pipeline kill.
- add_start  out  1  one-cycle start pulse to the add pipe.
- mul_start  out  1  one-cycle start pulse to the mul pipe.
- div_start  out  1  one-cycle start pulse to the divider.
- div_kill  out  1  one-cycle abort pulse to the divider.
- div_done  in  1  divider result ready (one-cycle pulse).
- wb_valid  out  1  writeback this cycle.
- wb_rd  out  5  writeback destination.
- wb_sel  out  2  result mux select: 00 add, 01 mul, 10 div.
- illegal  out  1  pulse when issue_pkt is not one-hot.
- busy  out  1  any op in flight.

Behaviour:
- Reset: rsv, rd/sel shadow arrays, div_rd and all outputs are 0; divide FSM is IDLE.
- rsv[i] = 1 means a result writes back i cycles from now. Each cycle the register shifts toward index 0; the rd/sel arrays shift in parallel.
- Add fire at cycle t:
  - Requires rsv[ADD_LAT] == 0 before the shift.
  - Sets the post-shift slot ADD_LAT-1 with rd and sel=00.
  - Pulses add_start in cycle t; wb_valid at t+ADD_LAT.
- Mul fire: same rule using MUL_LAT and sel=01.
- Pipelined slots are never delayed.
- wb_valid = rsv[0] & ~flush; wb_rd and wb_sel come from slot 0.
- Divide FSM:
  - IDLE: a div fire pulses div_start, latches issue_rd into div_rd, and goes to RUN.
  - RUN: on div_done, go to HOLD. div_done seen in IDLE or HOLD is ignored.
  - HOLD: when rsv[0] == 0, drive wb_valid=1, wb_sel=10, wb_rd=div_rd, and go to IDLE. Otherwise stay in HOLD.
- issue_ready (combinational from issue_pkt, rsv and FSM state):
  - Forced to 0 if flush=1 or the FSM is in HOLD. Blocking all issue in HOLD guarantees the div result writes within MUL_LAT+1 cycles.
  - Add needs its reservation slot free; mul likewise.
  - Div needs the FSM in IDLE.
- Illegal packet: if issue_valid=1 and issue_pkt is not one-hot (000 or multi-hot):
  - issue_ready=1 and illegal pulses.
  - No start pulse and no reservation.
- Flush:
  - Clears rsv and returns the FSM to IDLE.
  - Pulses div_kill if the FSM was in RUN or HOLD.
  - Suppresses wb_valid in the same cycle.
  - Results already inside the pipes are discarded.
- busy = |rsv | (FSM != IDLE).
- Issue and slot-0 writeback in the same cycle: legal; the shift and the new reservation apply together.
- Reset mid-operation: state is cleared immediately (asynchronous); no div_kill is generated.

Decomposition:
- fp_pkt_t is reused from the shared types package.
- Add a wb_sel_t enum (FPWB_ADD, FPWB_MUL, FPWB_DIV) and a div FSM state enum (IDLE, RUN, HOLD) to that package.
- One natural sub-module: fp_wb_rsv, the reservation shift register holding rsv, rd and sel, with set-at-index and clear ports.

Test Plan:
1. Add with rd=5 issued at cycle 10 -> add_start at 10; wb_valid=1, wb_rd=5, wb_sel=00 at cycle 13 only.
2. Mul with rd=7 at cycle 0, then add with rd=9 at cycle 1 -> both target cycle 4; the add sees issue_ready=0 at cycle 1. The add re-issued at cycle 2 writes back at cycle 5.
3. Div with rd=3; div_done at cycle 20 while a mul reservation sits at rsv[0] in cycle 21 -> FSM in HOLD. The div writeback occurs at the first cycle with rsv[0]=0; issue_ready=0 throughout HOLD.
4. A second div issued while the FSM is in RUN -> issue_ready=0; after the first div's writeback (FSM back in IDLE), issue_ready=1 and div_start pulses.
5. Flush with adds in flight and the FSM in RUN -> div_kill pulses once, busy=0 the next cycle, and no wb_valid follows.
6. issue_pkt=3'b110 with issue_valid=1 -> issue_ready=1, illegal=1, no start pulses, and busy unchanged.

Source files
------------

// File: rtl/fp_issue_sched_pkg.sv
// Shared FP issue types: decoded op packet, writeback mux select, divide sequencing state.
package fp_issue_sched_pkg;

   typedef struct packed {
      logic fp_add;
      logic fp_mul;
      logic fp_div;
   } fp_pkt_t;

   typedef enum logic [1:0] {
      FPWB_ADD = 2'b00,
      FPWB_MUL = 2'b01,
      FPWB_DIV = 2'b10
   } wb_sel_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } div_state_t;

   function automatic logic is_onehot(input fp_pkt_t p);
      return (p == 3'b100) || (p == 3'b010) || (p == 3'b001);
   endfunction

endpackage

// File: rtl/fp_wb_rsv.sv
// Writeback reservation shift register: slot i holds a result due i cycles from now.
module fp_wb_rsv
   import fp_issue_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     set_en,
   input  logic [$clog2(DEPTH)-1:0] set_idx,
   input  logic [4:0]               set_rd,
   input  wb_sel_t                  set_sel,
   output logic [DEPTH-1:0]         rsv,
   output logic [4:0]               rd0,
   output wb_sel_t                  sel0
);

   logic [DEPTH-1:0] rsv_q, rsv_d;
   logic [4:0]       rd_q  [DEPTH];
   logic [4:0]       rd_d  [DEPTH];
   wb_sel_t          sel_q [DEPTH];
   wb_sel_t          sel_d [DEPTH];

   always_comb begin
      rsv_d = {1'b0, rsv_q[DEPTH-1:1]};
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
         rd_d[i]  = rd_q[i+1];
         sel_d[i] = sel_q[i+1];
      end
      rd_d[DEPTH-1]  = '0;
      sel_d[DEPTH-1] = FPWB_ADD;
      // set_idx addresses the post-shift image, so shift and new reservation land together
      if (clr) begin
         rsv_d = '0;
      end else if (set_en) begin
         rsv_d[set_idx] = 1'b1;
         rd_d[set_idx]  = set_rd;
         sel_d[set_idx] = set_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsv_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i]  <= '0;
            sel_q[i] <= FPWB_ADD;
         end
      end else begin
         rsv_q <= rsv_d;
         rd_q  <= rd_d;
         sel_q <= sel_d;
      end
   end

   assign rsv  = rsv_q;
   assign rd0  = rd_q[0];
   assign sel0 = sel_q[0];

endmodule

// File: rtl/fp_issue_sched.sv
// FP issue/writeback scheduler: starts add/mul/div units and keeps the single
// writeback port collision-free via slot reservations and a divide hold state.
module fp_issue_sched
   import fp_issue_sched_pkg::*;
#(
   parameter int unsigned ADD_LAT   = 3,
   parameter int unsigned MUL_LAT   = 4,
   parameter int unsigned RSV_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   input  fp_pkt_t    issue_pkt,
   input  logic [4:0] issue_rd,
   output logic       issue_ready,
   input  logic       flush,
   output logic       add_start,
   output logic       mul_start,
   output logic       div_start,
   output logic       div_kill,
   input  logic       div_done,
   output logic       wb_valid,
   output logic [4:0] wb_rd,
   output wb_sel_t    wb_sel,
   output logic       illegal,
   output logic       busy
);

   localparam int unsigned IW = $clog2(RSV_DEPTH);

   logic [RSV_DEPTH-1:0] rsv;
   logic [4:0]           rd0;
   wb_sel_t              sel0;
   div_state_t           state_q, state_d;
   logic [4:0]           div_rd_q, div_rd_d;
   logic                 onehot, fire, set_en;
   logic [IW-1:0]        set_idx;
   wb_sel_t              set_sel;

   always_comb begin
      onehot      = is_onehot(issue_pkt);
      issue_ready = 1'b0;
      // HOLD blocks all issue so the pending divide result drains within MUL_LAT+1 cycles
      if (!flush && state_q != HOLD) begin
         if (!onehot)                issue_ready = 1'b1;
         else if (issue_pkt.fp_add)  issue_ready = ~rsv[ADD_LAT];
         else if (issue_pkt.fp_mul)  issue_ready = ~rsv[MUL_LAT];
         else                        issue_ready = (state_q == IDLE);
      end

      fire      = issue_valid & issue_ready;
      illegal   = fire & ~onehot;
      add_start = fire & onehot & issue_pkt.fp_add;
      mul_start = fire & onehot & issue_pkt.fp_mul;
      div_start = fire & onehot & issue_pkt.fp_div;

      set_en  = add_start | mul_start;
      set_idx = add_start ? IW'(ADD_LAT - 1) : IW'(MUL_LAT - 1);
      set_sel = add_start ? FPWB_ADD : FPWB_MUL;

      state_d  = state_q;
      div_rd_d = div_rd_q;
      div_kill = flush & (state_q != IDLE);
      wb_valid = rsv[0];
      wb_rd    = rd0;
      wb_sel   = sel0;

      case (state_q)
         IDLE: if (div_start) begin
            state_d  = RUN;
            div_rd_d = issue_rd;
         end
         RUN:  if (div_done) state_d = HOLD;
         HOLD: if (!rsv[0]) begin
            wb_valid = 1'b1;
            wb_rd    = div_rd_q;
            wb_sel   = FPWB_DIV;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d  = IDLE;
         wb_valid = 1'b0;
      end

      busy = (|rsv) | (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         div_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         div_rd_q <= div_rd_d;
      end
   end

   fp_wb_rsv #(.DEPTH(RSV_DEPTH)) u_rsv (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .set_en  (set_en),
      .set_idx (set_idx),
      .set_rd  (issue_rd),
      .set_sel (set_sel),
      .rsv     (rsv),
      .rd0     (rd0),
      .sel0    (sel0)
   );

endmodule

// File: tb/tb_fp_issue_sched.sv
// Scoreboard bench for fp_issue_sched: a cycle-indexed writeback schedule model
// predicts control outputs; a negedge monitor pops expected writebacks.
module tb_fp_issue_sched;

   localparam int ADD_LAT = 3;
   localparam int MUL_LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic [2:0] issue_pkt;
   logic [4:0] issue_rd;
   logic       issue_ready;
   logic       flush;
   logic       add_start, mul_start, div_start, div_kill;
   logic       div_done;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic [1:0] wb_sel;
   logic       illegal;
   logic       busy;

   fp_issue_sched #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .RSV_DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_pkt   (issue_pkt),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .flush       (flush),
      .add_start   (add_start),
      .mul_start   (mul_start),
      .div_start   (div_start),
      .div_kill    (div_kill),
      .div_done    (div_done),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_sel      (wb_sel),
      .illegal     (illegal),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int rd;
      int sel;
   } exp_t;

   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   running = 0;
   // divide progress: 0 none, 1 computing, 2 result waiting for writeback at dwb
   int   dphase = 0;
   int   drd = 0;
   int   dwb = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit taken(input int c);
      foreach (expq[i]) if (expq[i].cyc == c && expq[i].sel != 2) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pending_pipe(input int c);
      int n = 0;
      foreach (expq[i]) if (expq[i].cyc >= c && expq[i].sel != 2) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      int idx;
      if (running) begin
         idx = -1;
         foreach (expq[i]) if (expq[i].cyc == cyc) idx = i;
         chk("wb_valid", {7'd0, wb_valid}, {7'd0, idx >= 0});
         if (idx >= 0) begin
            if (wb_valid === 1'b1) begin
               chk("wb_rd", {3'd0, wb_rd}, 8'(expq[idx].rd));
               chk("wb_sel", {6'd0, wb_sel}, 8'(expq[idx].sel));
            end
            expq.delete(idx);
         end
      end
   end

   task automatic step(input bit v, input logic [2:0] pkt, input int rd, input bit fl, input bit dn);
      bit oh, rdy, fire, e_busy, e_kill;
      @(posedge clk);
      #2;
      cyc++;
      issue_valid = v;
      issue_pkt   = pkt;
      issue_rd    = rd[4:0];
      flush       = fl;
      div_done    = dn;

      if (dphase == 2 && cyc > dwb) dphase = 0;
      oh = ($countones(pkt) == 1);
      if (fl || dphase == 2)  rdy = 1'b0;
      else if (!oh)           rdy = 1'b1;
      else if (pkt[2])        rdy = !taken(cyc + ADD_LAT);
      else if (pkt[1])        rdy = !taken(cyc + MUL_LAT);
      else                    rdy = (dphase == 0);
      fire   = v && rdy;
      e_busy = (pending_pipe(cyc) > 0) || (dphase != 0);
      e_kill = fl && (dphase != 0);

      if (fl) begin
         for (int i = expq.size() - 1; i >= 0; i--)
            if (expq[i].cyc >= cyc) expq.delete(i);
         dphase = 0;
      end else begin
         if (fire && oh && pkt[2]) expq.push_back('{cyc + ADD_LAT, rd, 0});
         if (fire && oh && pkt[1]) expq.push_back('{cyc + MUL_LAT, rd, 1});
         if (dn && dphase == 1) begin
            dphase = 2;
            dwb = cyc + 1;
            while (taken(dwb)) dwb++;
            expq.push_back('{dwb, drd, 2});
         end
         if (fire && oh && pkt[0]) begin
            dphase = 1;
            drd = rd;
         end
      end

      @(negedge clk);
      chk("issue_ready", {7'd0, issue_ready}, {7'd0, rdy});
      chk("add_start",   {7'd0, add_start},   {7'd0, fire && oh && pkt[2]});
      chk("mul_start",   {7'd0, mul_start},   {7'd0, fire && oh && pkt[1]});
      chk("div_start",   {7'd0, div_start},   {7'd0, fire && oh && pkt[0]});
      chk("illegal",     {7'd0, illegal},     {7'd0, fire && !oh});
      chk("div_kill",    {7'd0, div_kill},    {7'd0, e_kill});
      chk("busy",        {7'd0, busy},        {7'd0, e_busy});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 3'b000, 0, 0, 0);
   endtask

   initial begin
      logic [2:0] pk;
      int r;
      rst = 1'b1;
      issue_valid = 1'b0;
      issue_pkt = 3'b000;
      issue_rd = 5'd0;
      flush = 1'b0;
      div_done = 1'b0;
      #3;
      chk("rst_wb_valid", {7'd0, wb_valid}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_starts", {5'd0, add_start, mul_start, div_start}, 8'd0);
      chk("rst_wb_rd", {3'd0, wb_rd}, 8'd0);
      #9;
      rst = 1'b0;
      running = 1'b1;

      // single add
      step(1, 3'b100, 5, 0, 0);
      idle(5);
      // mul then colliding add, add retried
      step(1, 3'b010, 7, 0, 0);
      step(1, 3'b100, 9, 0, 0);
      step(1, 3'b100, 9, 0, 0);
      idle(5);
      // div result held behind a mul writeback, issue attempts during hold
      step(1, 3'b001, 3, 0, 0);
      idle(2);
      step(1, 3'b010, 12, 0, 0);
      step(1, 3'b001, 4, 0, 0);
      step(0, 3'b000, 0, 0, 1);
      step(1, 3'b100, 13, 0, 0);
      step(1, 3'b100, 13, 0, 0);
      step(1, 3'b001, 4, 0, 0);
      step(1, 3'b001, 4, 0, 1);
      idle(3);
      step(0, 3'b000, 0, 0, 1);
      idle(4);
      // flush with adds in flight and divide running
      step(1, 3'b001, 8, 0, 0);
      step(1, 3'b100, 10, 0, 0);
      step(1, 3'b100, 11, 0, 0);
      step(1, 3'b100, 12, 1, 0);
      idle(6);
      // illegal packets
      step(1, 3'b010, 2, 0, 0);
      step(1, 3'b110, 1, 0, 0);
      step(1, 3'b000, 1, 0, 0);
      step(1, 3'b111, 1, 0, 0);
      idle(6);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 15);
         if (r < 5)       pk = 3'b100;
         else if (r < 10) pk = 3'b010;
         else if (r < 13) pk = 3'b001;
         else             pk = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 3) != 0), pk, $urandom_range(0, 31),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
      end

      for (int n = 0; n < 20; n++) step(0, 3'b000, 0, 0, (n == 0));
      idle(12);
      chk("drained", 8'(expq.size()), 8'd0);
      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
